// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: control-code decode, operand-2 select and
// EX/MEM / MEM/WB forwarding, registered behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_aluop,
    input  logic [5:0]        i_funct,
    input  logic [5:0]        i_opcode,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [15:0]       i_imm,
    input  logic              i_alusrc,
    input  logic              i_exmem_we,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_data,
    input  logic              i_memwb_we,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_data,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [3:0]        o_control,
    output logic [DATA_W-1:0] o_store_data,
    output logic              o_illegal
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    // Returns {illegal, control}; unsupported encodings fall back to ADD.
    function automatic logic [4:0] decode_control(
        input logic [1:0] aluop,
        input logic [5:0] funct,
        input logic [5:0] opcode
    );
        logic [4:0] res;
        res = {1'b0, CTL_ADD};
        case (aluop)
            2'b00: res = {1'b0, CTL_ADD};
            2'b01: res = {1'b0, CTL_SUB};
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: res = {1'b0, CTL_ADD};
                    6'b100010, 6'b100011: res = {1'b0, CTL_SUB};
                    6'b100100:            res = {1'b0, CTL_AND};
                    6'b100101:            res = {1'b0, CTL_OR};
                    6'b100111:            res = {1'b0, CTL_NOR};
                    6'b101010:            res = {1'b0, CTL_SLT};
                    default:              res = {1'b1, CTL_ADD};
                endcase
            end
            2'b11: begin
                case (opcode)
                    6'b001000, 6'b001001: res = {1'b0, CTL_ADD};
                    6'b001100:            res = {1'b0, CTL_AND};
                    6'b001101:            res = {1'b0, CTL_OR};
                    6'b001010:            res = {1'b0, CTL_SLT};
                    default:              res = {1'b1, CTL_ADD};
                endcase
            end
            default: res = {1'b1, CTL_ADD};
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] extend_imm(
        input logic [1:0]  aluop,
        input logic [5:0]  opcode,
        input logic [15:0] imm
    );
        logic [DATA_W-1:0] res;
        if (aluop == 2'b11 && (opcode == 6'b001100 || opcode == 6'b001101)) begin
            res = {{(DATA_W-16){1'b0}}, imm};
        end else begin
            res = {{(DATA_W-16){imm[15]}}, imm};
        end
        return res;
    endfunction

    // EX/MEM beats MEM/WB; register 0 always reads the fallback value.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] fallback,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] res;
        if (ex_we && ex_rd == src && src != {REG_AW{1'b0}}) begin
            res = ex_data;
        end else if (wb_we && wb_rd == src && src != {REG_AW{1'b0}}) begin
            res = wb_data;
        end else begin
            res = fallback;
        end
        return res;
    endfunction

    logic              valid_r;
    logic              illegal_r;
    logic [3:0]        control_r;
    logic [DATA_W-1:0] op1_r;
    logic [DATA_W-1:0] op2_r;
    logic [DATA_W-1:0] store_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic              alusrc_r;

    logic              ready_s;
    logic              load_s;
    logic [4:0]        dec_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;
    logic [DATA_W-1:0] op2_s;
    logic [DATA_W-1:0] held_op1_s;
    logic [DATA_W-1:0] held_rt_s;
    logic [DATA_W-1:0] held_op2_s;

    assign ready_s = !valid_r || i_ready;
    assign load_s  = i_valid && ready_s;

    // Incoming decode/forwarding, plus re-forwarding of a held instruction.
    always_comb begin
        dec_s      = decode_control(i_aluop, i_funct, i_opcode);
        imm_ext_s  = extend_imm(i_aluop, i_opcode, i_imm);
        fwd_rs_s   = forward(i_rs, i_rs_data, i_exmem_we, i_exmem_rd, i_exmem_data,
                             i_memwb_we, i_memwb_rd, i_memwb_data);
        fwd_rt_s   = forward(i_rt, i_rt_data, i_exmem_we, i_exmem_rd, i_exmem_data,
                             i_memwb_we, i_memwb_rd, i_memwb_data);
        held_op1_s = forward(rs_r, op1_r, i_exmem_we, i_exmem_rd, i_exmem_data,
                             i_memwb_we, i_memwb_rd, i_memwb_data);
        held_rt_s  = forward(rt_r, store_r, i_exmem_we, i_exmem_rd, i_exmem_data,
                             i_memwb_we, i_memwb_rd, i_memwb_data);
        if (i_alusrc) begin
            op2_s = imm_ext_s;
        end else begin
            op2_s = fwd_rt_s;
        end
        if (alusrc_r) begin
            held_op2_s = op2_r;
        end else begin
            held_op2_s = held_rt_s;
        end
    end

    // Output register: reset > flush > load > hold > drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
            control_r <= CTL_ADD;
            op1_r     <= {DATA_W{1'b0}};
            op2_r     <= {DATA_W{1'b0}};
            store_r   <= {DATA_W{1'b0}};
            rs_r      <= {REG_AW{1'b0}};
            rt_r      <= {REG_AW{1'b0}};
            alusrc_r  <= 1'b0;
        end else if (i_flush) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r   <= 1'b1;
            illegal_r <= dec_s[4];
            control_r <= dec_s[3:0];
            op1_r     <= fwd_rs_s;
            op2_r     <= op2_s;
            store_r   <= fwd_rt_s;
            rs_r      <= i_rs;
            rt_r      <= i_rt;
            alusrc_r  <= i_alusrc;
        end else if (valid_r && !i_ready) begin
            op1_r   <= held_op1_s;
            op2_r   <= held_op2_s;
            store_r <= held_rt_s;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign o_ready      = ready_s;
    assign o_valid      = valid_r;
    assign o_illegal    = illegal_r;
    assign o_control    = control_r;
    assign o_op1        = op1_r;
    assign o_op2        = op2_r;
    assign o_store_data = store_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected outputs are queued at drive
// time and popped when the stage presents a valid instruction.
module tb_alu_issue_stage;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_alusrc, i_exmem_we, i_memwb_we, i_flush, i_ready;
    logic [1:0]  i_aluop;
    logic [5:0]  i_funct, i_opcode;
    logic [4:0]  i_rs, i_rt, i_exmem_rd, i_memwb_rd;
    logic [31:0] i_rs_data, i_rt_data, i_exmem_data, i_memwb_data;
    logic [15:0] i_imm;
    logic        o_ready, o_valid, o_illegal;
    logic [31:0] o_op1, o_op2, o_store_data;
    logic [3:0]  o_control;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] store;
        logic [3:0]  ctl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    exp_t e;
    exp_t x;

    alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_aluop(i_aluop), .i_funct(i_funct), .i_opcode(i_opcode),
        .i_rs(i_rs), .i_rt(i_rt), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_imm(i_imm), .i_alusrc(i_alusrc),
        .i_exmem_we(i_exmem_we), .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data),
        .i_memwb_we(i_memwb_we), .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data),
        .i_flush(i_flush), .i_ready(i_ready), .o_valid(o_valid),
        .o_op1(o_op1), .o_op2(o_op2), .o_control(o_control),
        .o_store_data(o_store_data), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    assign got = {o_op1, o_op2, o_store_data, o_control, o_illegal};

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aop, input logic [5:0] fn, input logic [5:0] opc,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic [31:0] sd, input logic [31:0] td,
                         input logic [15:0] im, input logic src);
        i_aluop = aop; i_funct = fn; i_opcode = opc; i_rs = s; i_rt = t;
        i_rs_data = sd; i_rt_data = td; i_imm = im; i_alusrc = src;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mr, input logic [31:0] md);
        i_exmem_we = ew; i_exmem_rd = er; i_exmem_data = ed;
        i_memwb_we = mw; i_memwb_rd = mr; i_memwb_data = md;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1; i_valid = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive(2'b01, 6'd0, 6'd0, 5'd1, 5'd2, 32'd11, 32'd22, 16'd0, 1'b0);
        step(); step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_control !== 4'b0010) begin errors++; $display("FAIL reset_control: got %b want 0010", o_control); end
        checks++; if ({o_op1, o_op2, o_store_data} !== 96'd0) begin errors++; $display("FAIL reset_data: op1 %h op2 %h store %h want 0", o_op1, o_op2, o_store_data); end
        checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", o_illegal); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        i_rst = 1'b0;
        x = {32'd11, 32'd22, 32'd22, 4'b0110, 1'b0}; sb.push_back(x);
        step();
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL first_load: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (o_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL first_load: valid %b got %h want %h", o_valid, got, e); end
        end
        i_valid = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_rtype();
        logic [1:0] aop [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        logic [5:0] fn  [11] = '{6'b101010, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                 6'b100101, 6'b100111, 6'b111111, 6'b111111, 6'b111111};
        logic [3:0] ctl [11] = '{4'b0111, 4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
                                 4'b0001, 4'b1100, 4'b0010, 4'b0010, 4'b0110};
        logic       ill [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        i_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 11; i++) begin
            drive(aop[i], fn[i], 6'b000000, 5'd3, 5'd4, 32'd5 + 32'(i), 32'd7, 16'hFFFF, 1'b0);
            i_valid = 1'b1;
            x = {32'd5 + 32'(i), 32'd7, 32'd7, ctl[i], ill[i]}; sb.push_back(x);
            step();
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL rtype_%0d: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL rtype_%0d: valid %b got %h want %h", i, o_valid, got, e); end
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_immediate();
        logic [5:0]  opc [7] = '{6'b001000, 6'b001101, 6'b001100, 6'b001010, 6'b001001, 6'b000000, 6'b001101};
        logic [15:0] im  [7] = '{16'hFFFF, 16'hFFFF, 16'h8001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF};
        logic        src [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] op2 [7] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h00008001, 32'hFFFF8000,
                                 32'h00007FFF, 32'hFFFFFFFF, 32'h00001234};
        logic [3:0]  ctl [7] = '{4'b0010, 4'b0001, 4'b0000, 4'b0111, 4'b0010, 4'b0010, 4'b0001};
        logic        ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        i_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 6'b100100, opc[i], 5'd5, 5'd6, 32'h100, 32'h1234, im[i], src[i]);
            i_valid = 1'b1;
            x = {32'h100, op2[i], 32'h1234, ctl[i], ill[i]}; sb.push_back(x);
            step();
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL imm_%0d: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL imm_%0d: valid %b got %h want %h", i, o_valid, got, e); end
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_forward();
        logic [31:0] w1, w2, w3;
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin drive(2'b00, 6'd0, 6'd0, 5'd2, 5'd7, 32'd1, 32'd2, 16'd0, 1'b0);
                         set_fwd(1'b1, 5'd2, 32'hAA, 1'b1, 5'd2, 32'hBB);
                         w1 = 32'hAA; w2 = 32'd2; w3 = 32'd2; end
                1: begin drive(2'b00, 6'd0, 6'd0, 5'd0, 5'd9, 32'h33, 32'h44, 16'd0, 1'b0);
                         set_fwd(1'b1, 5'd0, 32'hEE, 1'b1, 5'd0, 32'hDD);
                         w1 = 32'h33; w2 = 32'h44; w3 = 32'h44; end
                2: begin drive(2'b00, 6'd0, 6'd0, 5'd8, 5'd4, 32'd1, 32'd2, 16'd0, 1'b0);
                         set_fwd(1'b0, 5'd8, 32'h77, 1'b1, 5'd4, 32'h99);
                         w1 = 32'd1; w2 = 32'h99; w3 = 32'h99; end
                3: begin drive(2'b00, 6'd0, 6'd0, 5'd8, 5'd4, 32'd3, 32'd2, 16'h0010, 1'b1);
                         set_fwd(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0);
                         w1 = 32'd3; w2 = 32'h10; w3 = 32'h55; end
                default: begin drive(2'b00, 6'd0, 6'd0, 5'd4, 5'd4, 32'd3, 32'd2, 16'd0, 1'b0);
                         set_fwd(1'b1, 5'd4, 32'h66, 1'b1, 5'd4, 32'h67);
                         w1 = 32'h66; w2 = 32'h66; w3 = 32'h66; end
            endcase
            i_valid = 1'b1;
            x = {w1, w2, w3, 4'b0010, 1'b0}; sb.push_back(x);
            step();
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL fwd_%0d: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL fwd_%0d: valid %b got %h want %h", i, o_valid, got, e); end
            end
        end
        i_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
    endtask

    task automatic test_stall();
        i_ready = 1'b0; i_valid = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive(2'b10, 6'b100000, 6'd0, 5'd3, 5'd4, 32'd5, 32'd7, 16'd0, 1'b0);
        step();
        checks++; if (o_valid !== 1'b1 || o_op2 !== 32'd7) begin errors++; $display("FAIL stall_load: valid %b op2 %h want 1/7", o_valid, o_op2); end
        drive(2'b01, 6'd0, 6'd0, 5'd6, 5'd7, 32'h1111, 32'h1234, 16'd0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd9);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (o_op2 !== 32'd9 || o_store_data !== 32'd9 || o_op1 !== 32'd5 || o_control !== 4'b0010 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: op1 %h op2 %h st %h ctl %b v %b rdy %b want 5/9/9/0010/1/0", c, o_op1, o_op2, o_store_data, o_control, o_valid, o_ready);
            end
        end
        set_fwd(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0);
        step();
        checks++; if (o_op1 !== 32'h55 || o_op2 !== 32'd9) begin errors++; $display("FAIL stall_refwd_rs: op1 %h op2 %h want 55/9", o_op1, o_op2); end
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        i_valid = 1'b0; i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", o_ready); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", o_valid); end
        // Immediate operand stays put while held; only the store data follows rt.
        i_ready = 1'b0; i_valid = 1'b1;
        drive(2'b11, 6'd0, 6'b001101, 5'd3, 5'd4, 32'd5, 32'd7, 16'h00F0, 1'b1);
        step();
        i_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd9);
        step();
        checks++;
        if (o_op2 !== 32'hF0 || o_store_data !== 32'd9 || o_control !== 4'b0001) begin
            errors++; $display("FAIL stall_imm_hold: op2 %h st %h ctl %b want f0/9/0001", o_op2, o_store_data, o_control);
        end
        i_rst = 1'b1;
        step();
        checks++; if (o_valid !== 1'b0 || o_control !== 4'b0010) begin errors++; $display("FAIL reset_mid_hold: v %b ctl %b want 0/0010", o_valid, o_control); end
        i_rst = 1'b0; i_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1;
        drive(2'b01, 6'd0, 6'd0, 5'd1, 5'd2, 32'd40, 32'd30, 16'd0, 1'b0);
        step();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL flush_preload: got %b want 1", o_valid); end
        i_flush = 1'b1;
        drive(2'b00, 6'd0, 6'd0, 5'd1, 5'd2, 32'd1, 32'd1, 16'd0, 1'b0);
        step();
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_held: v %b rdy %b want 0/1", o_valid, o_ready); end
        i_ready = 1'b1;
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_incoming: got %b want 0", o_valid); end
        i_flush = 1'b0;
        drive(2'b01, 6'd0, 6'd0, 5'd1, 5'd2, 32'd50, 32'd8, 16'd0, 1'b0);
        x = {32'd50, 32'd8, 32'd8, 4'b0110, 1'b0}; sb.push_back(x);
        step();
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL flush_recover: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (o_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL flush_recover: valid %b got %h want %h", o_valid, got, e); end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 6'd0, 6'd0, 5'(10 + i), 5'(20 + i), 32'h1000 * 32'(i + 1), 32'(i + 3), 16'd0, 1'b0);
            i_valid = 1'b1;
            x = {32'h1000 * 32'(i + 1), 32'(i + 3), 32'(i + 3), 4'b0010, 1'b0}; sb.push_back(x);
            step();
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL b2b_%0d: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o_valid !== 1'b1 || o_ready !== 1'b1 || got !== e) begin
                    errors++; $display("FAIL b2b_%0d: valid %b ready %b got %h want %h", i, o_valid, o_ready, got, e);
                end
            end
        end
        i_valid = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL b2b_drain: valid %b pending %0d want 0/0", o_valid, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_immediate();
        test_forward();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
